mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
- Bus initiator that drives the CPU's 64 KB byte-wide RAM, which is level-sensitive and has an R_W/enable/addr/data/outp interface.
- Accepts byte or 16-bit word load/store requests from the core over a valid/ready handshake.
- Sequences them into single-byte memory cycles, with words stored little-endian.
- Returns read data and a write acknowledgement through a one-cycle response strobe.

Parameters:
- READ_WAIT, 1, cycles that enable/R_W=1/addr are held per read byte before mem_outp is sampled (legal range 1..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_word  in  1  1 = 16-bit access (two bytes), 0 = byte access
- req_addr  in  16  byte address (low byte address for word accesses)
- req_wdata  in  16  store data; bits [7:0] are used for a byte store
- rsp_valid  out  1  one-cycle pulse when the access completes (load or store)
- rsp_rdata  out  16  load data; {8'h00, byte} for byte loads; 16'h0000 for stores
- mem_R_W  out  1  to RAM R_W: 1 = read, 0 = write
- mem_enable  out  1  to RAM enable
- mem_addr  out  16  to RAM addr
- mem_data  out  8  to RAM data
- mem_outp  in  8  from RAM outp

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst).
- All outputs are registered.
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, mem_enable = 0, mem_R_W = 1, mem_addr = 0, mem_data = 0.
- Bus invariant: mem_R_W = 1 whenever mem_enable = 0.
- Bus invariant: mem_R_W = 0 is asserted only together with mem_enable = 1.
- Bus invariant: mem_addr and mem_data never change while mem_enable = 1 and mem_R_W = 0, so the RAM cannot take a spurious write.
- Handshake: a request is accepted on an edge where req_valid && req_ready, in IDLE only.
- On acceptance, req_we, req_word, req_addr and req_wdata are latched, and req_ready drops the same edge.
- Request inputs are ignored while busy.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, WR_GAP, DONE.
- From IDLE on accept: go to RD_LO if req_we = 0, else WR_LO. mem_addr = req_addr; mem_data = req_wdata[7:0] for stores.
- RD_LO / RD_HI: mem_enable = 1, mem_R_W = 1, held for READ_WAIT cycles (internal 4-bit counter).
- On the last read cycle's edge, mem_outp is captured into rdata[7:0] (RD_LO) or rdata[15:8] (RD_HI).
- After RD_LO: a word access goes to RD_HI with mem_addr = addr+1; a byte access goes to DONE.
- The mem_outp value is sampled as-is; X/Z is not filtered.
- WR_LO / WR_HI: exactly one cycle with mem_enable = 1, mem_R_W = 0. Then WR_GAP: mem_enable = 0, mem_R_W = 1, one cycle.
- During WR_GAP, mem_addr/mem_data are updated for the next byte (addr+1, wdata[15:8]) if WR_HI is pending. Otherwise WR_GAP goes to DONE.
- DONE: rsp_valid = 1 for exactly one cycle, with rsp_rdata valid. mem_enable = 0. Next state is IDLE, and req_ready = 1 again.
- rsp_valid is low in all other states.
- Address arithmetic is 16-bit modulo: word access at 16'hFFFF uses 16'hFFFF for the low byte and 16'h0000 for the high byte.
- Latency (accept at edge T; cycles counted from T+1):
  - byte load: rsp_valid in cycle T+1+READ_WAIT.
  - word load: rsp_valid in cycle T+1+2*READ_WAIT.
  - byte store: rsp_valid in cycle T+3.
  - word store: rsp_valid in cycle T+5.
- Minimum request spacing: the next accept is possible on the edge ending the DONE cycle+1 (IDLE). There is no same-cycle DONE→accept overlap.
- Reset mid-operation: immediate return to reset values. No rollback — a word store interrupted after WR_LO leaves the low byte written and the high byte untouched. An in-flight response is dropped.
- Simultaneous rst and req_valid: rst wins; the request is not accepted.

Decomposition:
- Shared package mem_bus_pkg holds:
  - constants ADDR_W = 16, DATA_W = 8, RW_READ = 1'b1, RW_WRITE = 1'b0;
  - the state typedef/localparams IDLE..DONE, reused by the future fetch unit.
- No sub-module: a single FSM with one wait counter and a byte-lane mux fits in about 200 lines.

Test Plan:
- Reset: hold rst 2 cycles with req_valid = 1 → req_ready = 1, rsp_valid = 0, mem_enable = 0, mem_R_W = 1, mem_addr = 0; no request accepted.
- Byte load: RAM initialised ram[0] = F1, accept {we=0, word=0, addr=0000} at T → mem_enable = 1, mem_R_W = 1 in T+1; rsp_valid pulse in T+2 with rsp_rdata = 16'h00F1.
- Word load at addr 0000 (ram[1] = FF), READ_WAIT = 3 → mem_addr 0000 for 3 cycles, then 0001 for 3 cycles; rsp_valid in T+7 with rsp_rdata = 16'hFFF1.
- Word store wrap: data 16'h1234 at addr FFFF → write pulses at T+1 (FFFF, 34) and T+3 (0000, 12), with mem_enable = 0 in T+2 and T+4; rsp_valid in T+5.
- Word store wrap readback: follow with a word load at FFFF → rsp_rdata = 16'h1234.
- Busy and back-to-back: keep req_valid high with changing addr during a load → only the first request is serviced; the second is accepted on the first IDLE edge; no write pulse ever occurs for a load.
- Reset mid-store: assert rst in the WR_GAP cycle of a word store of 16'hABCD at addr 0010 → ram[0010] = CD, ram[0011] unchanged; outputs take reset values next cycle; no rsp_valid.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the byte-wide RAM bus initiator and future bus users.
// Holds bus widths, R_W polarity constants and the bus sequencer state type.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    WR_LO  = 3'd3,
    WR_HI  = 3'd4,
    WR_GAP = 3'd5,
    DONE   = 3'd6
  } bus_state_e;

endpackage

// File: rtl/mem_bus_master.sv
// Bus initiator for the 64 KB level-sensitive byte RAM.
// Turns byte / 16-bit word load/store requests into single-byte RAM cycles
// (little-endian words) and reports completion with a one-cycle strobe.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (accepted only in IDLE)
//   req_we, req_word       1 = store / 1 = 16-bit access
//   req_addr, req_wdata    byte address (low byte for words), store data
//   rsp_valid, rsp_rdata   completion pulse and load data (0 for stores)
//   mem_R_W, mem_enable    RAM control (R_W: 1 = read, 0 = write)
//   mem_addr, mem_data     RAM address and write data
//   mem_outp               RAM read data
// All outputs come straight from registers.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned READ_WAIT = 1  // read cycles per byte, 1..15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic                req_word,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rsp_rdata,
  output logic                mem_R_W,
  output logic                mem_enable,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  input  logic [DATA_W-1:0]   mem_outp
);

  // Counter runs from READ_WAIT-1 down to 0; the zero cycle is the sampling cycle.
  localparam logic [3:0] WaitInit = 4'(READ_WAIT - 1);

  bus_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                word_q, word_d;      // high byte still to be transferred
  logic [DATA_W-1:0]   wdata_hi_q, wdata_hi_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_q, mem_data_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    wdata_hi_d  = wdata_hi_q;
    rdata_d     = rdata_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    mem_en_d    = mem_en_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        mem_en_d    = 1'b0;
        mem_rw_d    = RW_READ;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          word_d      = req_word;
          wdata_hi_d  = req_wdata[15:8];
          rdata_d     = '0;
          mem_addr_d  = req_addr;
          mem_en_d    = 1'b1;
          if (req_we) begin
            state_d    = WR_LO;
            mem_rw_d   = RW_WRITE;
            mem_data_d = req_wdata[7:0];
          end else begin
            state_d  = RD_LO;
            mem_rw_d = RW_READ;
            cnt_d    = WaitInit;
          end
        end
      end

      RD_LO: begin
        if (cnt_q == 4'd0) begin
          rdata_d[7:0] = mem_outp;
          if (word_q) begin
            state_d    = RD_HI;
            mem_addr_d = mem_addr_q + 16'd1;
            cnt_d      = WaitInit;
          end else begin
            state_d     = DONE;
            mem_en_d    = 1'b0;
            rsp_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RD_HI: begin
        if (cnt_q == 4'd0) begin
          rdata_d[15:8] = mem_outp;
          state_d       = DONE;
          mem_en_d      = 1'b0;
          rsp_valid_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      // Next-byte address/data are loaded on the edge that ends the write pulse,
      // so they change only while enable is low.
      WR_LO: begin
        state_d  = WR_GAP;
        mem_en_d = 1'b0;
        mem_rw_d = RW_READ;
        if (word_q) begin
          mem_addr_d = mem_addr_q + 16'd1;
          mem_data_d = wdata_hi_q;
        end
      end

      WR_HI: begin
        state_d  = WR_GAP;
        mem_en_d = 1'b0;
        mem_rw_d = RW_READ;
      end

      WR_GAP: begin
        if (word_q) begin
          state_d  = WR_HI;
          word_d   = 1'b0;
          mem_en_d = 1'b1;
          mem_rw_d = RW_WRITE;
        end else begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end
      end

      DONE: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        mem_en_d    = 1'b0;
        mem_rw_d    = RW_READ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= 1'b0;
      wdata_hi_q  <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= RW_READ;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      wdata_hi_q  <= wdata_hi_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign mem_enable = mem_en_q;
  assign mem_R_W    = mem_rw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: byte RAM model on the pins, a
// transaction-level memory image as reference, per-feature test tasks.
module tb_mem_bus_master;

  localparam int RW = 3;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_word;
  logic [15:0] req_addr, req_wdata, rsp_rdata, mem_addr;
  logic        rsp_valid, mem_R_W, mem_enable;
  logic [7:0]  mem_data, mem_outp;

  logic [7:0]  ram [65536];
  logic [7:0]  ref_mem [65536];
  logic        mem_init;
  int          wr_cnt = 0;
  int          inv_bad = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  logic [15:0] tr_addr [16];
  logic [7:0]  tr_data [16];
  logic        tr_en [16];
  logic        tr_rw [16];

  mem_bus_master #(.READ_WAIT(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_word  (req_word),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_R_W   (mem_R_W),
    .mem_enable(mem_enable),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_outp  (mem_outp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    if (i == 0) return 8'hF1;
    if (i == 1) return 8'hFF;
    return 8'((i * 29 + 7) ^ (i >> 5));
  endfunction

  // Level-sensitive RAM: reads are combinational, a write lands while enable=1, R_W=0.
  assign mem_outp = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
    end else if (mem_enable === 1'b1 && mem_R_W === 1'b0) begin
      ram[mem_addr] <= mem_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Bus invariant: R_W must be high whenever enable is low.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_enable !== 1'b1 && mem_R_W !== 1'b1) inv_bad <= inv_bad + 1;
  end

  // Reference model: transaction-level view of memory.
  function automatic logic [15:0] model_load(input logic word, input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return word ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
  endfunction

  task automatic model_store(input logic word, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] a1;
    a1 = a + 16'd1;
    ref_mem[a] = d[7:0];
    if (word) ref_mem[a1] = d[15:8];
  endtask

  function automatic int exp_lat(input logic we, input logic word);
    if (we) return word ? 5 : 3;
    return word ? 1 + 2 * RW : 1 + RW;
  endfunction

  // Drives one request; lat = cycle index (from T+1) of the rsp_valid cycle.
  task automatic run_req(input logic we, input logic word, input logic [15:0] a,
                         input logic [15:0] d, output logic [15:0] rdata, output int lat);
    int guard;
    req_we = we; req_word = word; req_addr = a; req_wdata = d; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      if (lat <= 16) begin
        tr_addr[lat-1] = mem_addr; tr_data[lat-1] = mem_data;
        tr_en[lat-1] = mem_enable; tr_rw[lat-1] = mem_R_W;
      end
      @(posedge clk); #1; lat++;
    end
    if (lat <= 16) begin
      tr_addr[lat-1] = mem_addr; tr_data[lat-1] = mem_data;
      tr_en[lat-1] = mem_enable; tr_rw[lat-1] = mem_R_W;
    end
    rdata = rsp_rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_word = 1'b0;
    req_addr = 16'h1234; req_wdata = 16'(($urandom));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      mem_init = 1'b0;
      n_cmp++;
      if ({req_ready, rsp_valid, mem_enable, mem_R_W, mem_addr, mem_data, rsp_rdata} !==
          {1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0, 16'h0}) begin
        n_err++;
        $display("FAIL reset_values cyc%0d: got rdy=%b rsp=%b en=%b rw=%b a=%h d=%h rd=%h want 1 0 0 1 0000 00 0000",
                 c, req_ready, rsp_valid, mem_enable, mem_R_W, mem_addr, mem_data, rsp_rdata);
      end
    end
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (mem_enable !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_no_accept: got en=%b rdy=%b want en=0 rdy=1", mem_enable, req_ready);
    end
  endtask

  task automatic test_byte_load();
    logic [15:0] rd, exp;
    int lat;
    exp = model_load(1'b0, 16'h0000);
    run_req(1'b0, 1'b0, 16'h0000, 16'h0, rd, lat);
    n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL byte_load_data: got %h want %h", rd, exp); end
    n_cmp++;
    if (lat !== exp_lat(1'b0, 1'b0)) begin
      n_err++; $display("FAIL byte_load_latency: got %0d want %0d", lat, exp_lat(1'b0, 1'b0));
    end
    n_cmp++;
    if ({tr_en[0], tr_rw[0], tr_addr[0]} !== {1'b1, 1'b1, 16'h0000}) begin
      n_err++;
      $display("FAIL byte_load_bus: got en=%b rw=%b a=%h want 1 1 0000", tr_en[0], tr_rw[0], tr_addr[0]);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL byte_load_pulse: got rsp=%b rdy=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_word_load();
    logic [15:0] rd, exp, ea;
    int lat;
    exp = model_load(1'b1, 16'h0000);
    run_req(1'b0, 1'b1, 16'h0000, 16'h0, rd, lat);
    n_cmp++;
    if (rd !== exp) begin n_err++; $display("FAIL word_load_data: got %h want %h", rd, exp); end
    n_cmp++;
    if (lat !== exp_lat(1'b0, 1'b1)) begin
      n_err++; $display("FAIL word_load_latency: got %0d want %0d", lat, exp_lat(1'b0, 1'b1));
    end
    for (int i = 0; i < 2 * RW; i++) begin
      ea = (i < RW) ? 16'h0000 : 16'h0001;
      n_cmp++;
      if ({tr_en[i], tr_rw[i], tr_addr[i]} !== {1'b1, 1'b1, ea}) begin
        n_err++;
        $display("FAIL word_load_bus cyc%0d: got en=%b rw=%b a=%h want 1 1 %h",
                 i, tr_en[i], tr_rw[i], tr_addr[i], ea);
      end
    end
    n_cmp++;
    if (tr_en[2*RW] !== 1'b0) begin
      n_err++; $display("FAIL word_load_done_en: got %b want 0", tr_en[2*RW]);
    end
  endtask

  task automatic test_word_store_wrap();
    logic [15:0] rd, exp;
    int lat;
    model_store(1'b1, 16'hFFFF, 16'h1234);
    run_req(1'b1, 1'b1, 16'hFFFF, 16'h1234, rd, lat);
    n_cmp++;
    if (lat !== 5 || rd !== 16'h0000) begin
      n_err++; $display("FAIL store_wrap_rsp: got lat=%0d rd=%h want 5 0000", lat, rd);
    end
    n_cmp++;
    if ({tr_en[0], tr_rw[0], tr_addr[0], tr_data[0]} !== {1'b1, 1'b0, 16'hFFFF, 8'h34}) begin
      n_err++; $display("FAIL store_wrap_lo: got en=%b rw=%b a=%h d=%h want 1 0 ffff 34",
                        tr_en[0], tr_rw[0], tr_addr[0], tr_data[0]);
    end
    n_cmp++;
    if ({tr_en[2], tr_rw[2], tr_addr[2], tr_data[2]} !== {1'b1, 1'b0, 16'h0000, 8'h12}) begin
      n_err++; $display("FAIL store_wrap_hi: got en=%b rw=%b a=%h d=%h want 1 0 0000 12",
                        tr_en[2], tr_rw[2], tr_addr[2], tr_data[2]);
    end
    n_cmp++;
    if ({tr_en[1], tr_rw[1], tr_en[3], tr_rw[3]} !== 4'b0101) begin
      n_err++; $display("FAIL store_wrap_gap: got en/rw %b%b %b%b want 01 01",
                        tr_en[1], tr_rw[1], tr_en[3], tr_rw[3]);
    end
    exp = model_load(1'b1, 16'hFFFF);
    run_req(1'b0, 1'b1, 16'hFFFF, 16'h0, rd, lat);
    n_cmp++;
    if (rd !== exp || lat !== exp_lat(1'b0, 1'b1)) begin
      n_err++; $display("FAIL store_wrap_readback: got %h lat %0d want %h lat %0d",
                        rd, lat, exp, exp_lat(1'b0, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, a2, exp1, exp2;
    int lat, guard, w0, moved;
    a1 = 16'($urandom_range(16'h0100, 16'h7FFF));
    a2 = a1 + 16'h0123;
    exp1 = model_load(1'b0, a1);
    exp2 = model_load(1'b0, a2);
    w0 = wr_cnt;
    req_we = 1'b0; req_word = 1'b0; req_addr = a1; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    lat = 1; moved = 0;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      if (mem_addr !== a1) moved++;
      req_addr = 16'($urandom); req_word = 1'($urandom);
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (rsp_rdata !== exp1 || lat !== 1 + RW || moved !== 0) begin
      n_err++; $display("FAIL busy_first: got rd=%h lat=%0d moved=%0d want %h %0d 0",
                        rsp_rdata, lat, moved, exp1, 1 + RW);
    end
    req_addr = a2; req_word = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || mem_enable !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: got rdy=%b en=%b want 1 0", req_ready, mem_enable);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (mem_enable !== 1'b1 || mem_addr !== a2) begin
      n_err++; $display("FAIL b2b_second_accept: got en=%b a=%h want 1 %h", mem_enable, mem_addr, a2);
    end
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
    n_cmp++;
    if (rsp_rdata !== exp2 || lat !== 1 + RW) begin
      n_err++; $display("FAIL b2b_second: got rd=%h lat=%0d want %h %0d", rsp_rdata, lat, exp2, 1 + RW);
    end
    n_cmp++;
    if (wr_cnt !== w0) begin
      n_err++; $display("FAIL load_no_write: got %0d write pulses want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] old11;
    int guard, pulses;
    old11 = ref_mem[16'h0011];
    req_we = 1'b1; req_word = 1'b1; req_addr = 16'h0010; req_wdata = 16'hABCD; req_valid = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({req_ready, rsp_valid, mem_enable, mem_R_W, mem_addr, mem_data} !==
        {1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 8'h0}) begin
      n_err++; $display("FAIL midrst_values: got rdy=%b rsp=%b en=%b rw=%b a=%h d=%h want 1 0 0 1 0000 00",
                        req_ready, rsp_valid, mem_enable, mem_R_W, mem_addr, mem_data);
    end
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1 || mem_enable === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_err++; $display("FAIL midrst_quiet: got %0d active cycles want 0", pulses); end
    ref_mem[16'h0010] = 8'hCD;
    n_cmp++;
    if (ram[16'h0010] !== 8'hCD || ram[16'h0011] !== old11) begin
      n_err++; $display("FAIL midrst_ram: got %h %h want cd %h", ram[16'h0010], ram[16'h0011], old11);
    end
  endtask

  task automatic test_random();
    logic [15:0] a, d, rd, exp;
    logic we, word;
    int lat, bad;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); word = 1'($urandom); d = 16'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1))
                                      : 16'($urandom_range(0, 15));
      if (we) begin
        exp = 16'h0000;
        model_store(word, a, d);
      end else begin
        exp = model_load(word, a);
      end
      run_req(we, word, a, d, rd, lat);
      n_cmp++;
      if (rd !== exp || lat !== exp_lat(we, word)) begin
        n_err++; $display("FAIL random_%0d we=%b word=%b a=%h: got rd=%h lat=%0d want %h %0d",
                          n, we, word, a, rd, lat, exp, exp_lat(we, word));
      end
    end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[i] !== ref_mem[i]) bad++;
    if (ram[16'hFFFE] !== ref_mem[16'hFFFE] || ram[16'hFFFF] !== ref_mem[16'hFFFF]) bad++;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL random_ram_image: got %0d differing bytes want 0", bad); end
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (inv_bad !== 0) begin
      n_err++; $display("FAIL bus_rw_invariant: got %0d violating cycles want 0", inv_bad);
    end
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_word = 1'b0;
    req_addr = 16'h0; req_wdata = 16'h0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
    test_reset();
    test_byte_load();
    test_word_load();
    test_word_store_wrap();
    test_back_to_back();
    test_reset_mid_store();
    test_random();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
